// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// redirect flush windows and data-memory wait freezes. Optional HAZ_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             dm_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] fl_cnt_o,
    output logic [CNT_W-1:0] mw_cnt_o
);

    localparam int unsigned FC_W = 3;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [FC_W-1:0] FC_RELOAD  = FC_W'(FLUSH_CYCLES - 1);
    localparam bit              LONG_FLUSH = (FLUSH_CYCLES > 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [FC_W-1:0] cnt;
    logic [FC_W-1:0] cnt_nxt;
    logic            lu;
    logic            lu_stall;
    logic            freeze;
    logic            flush;

    always_comb begin
        lu = ex_is_load && (ex_rd_addr != 5'd0) &&
             ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
              (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    end

    // A nonzero cnt means a flush window is open; MEM_WAIT keeps it intact so the
    // window resumes once memory is ready.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        freeze    = 1'b0;
        flush     = 1'b0;
        lu_stall  = 1'b0;
        case (state)
            ST_RUN, ST_FLUSH, ST_MEM_WAIT: begin
                if (dm_busy) begin
                    freeze    = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    flush = 1'b1;
                    if (LONG_FLUSH) begin
                        cnt_nxt   = FC_RELOAD;
                        state_nxt = ST_FLUSH;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = ST_RUN;
                    end
                end else if (cnt != '0) begin
                    flush     = 1'b1;
                    cnt_nxt   = cnt - FC_W'(1);
                    state_nxt = (cnt == FC_W'(1)) ? ST_RUN : ST_FLUSH;
                end else begin
                    lu_stall  = lu;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Controls act in the decision cycle; reset masks them all.
    assign pc_stall    = rst_n & (freeze | lu_stall);
    assign ifid_stall  = rst_n & (freeze | lu_stall);
    assign ifid_flush  = rst_n & flush;
    assign idex_flush  = rst_n & (freeze | flush | lu_stall);
    assign exmem_stall = rst_n & freeze;
    assign state_o     = state;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] fl_cnt;
    logic [CNT_W-1:0] mw_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt <= '0;
            fl_cnt <= '0;
            mw_cnt <= '0;
        end else begin
            if (lu_stall && (lu_cnt != CNT_MAX)) lu_cnt <= lu_cnt + CNT_W'(1);
            if (ifid_flush && (fl_cnt != CNT_MAX)) fl_cnt <= fl_cnt + CNT_W'(1);
            if (exmem_stall && (mw_cnt != CNT_MAX)) mw_cnt <= mw_cnt + CNT_W'(1);
        end
    end

    assign lu_cnt_o = lu_cnt;
    assign fl_cnt_o = fl_cnt;
    assign mw_cnt_o = mw_cnt;
`else
    logic unused_perf;
    assign unused_perf = lu_stall;
    assign lu_cnt_o    = '0;
    assign fl_cnt_o    = '0;
    assign mw_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized
// run against a cycle-level behavioural model. Built with FLUSH_CYCLES=3, CNT_W=4.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FC = 3;
    localparam int unsigned CW = 4;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall}
    localparam logic [4:0] C_IDLE   = 5'b00000;
    localparam logic [4:0] C_FREEZE = 5'b11011;
    localparam logic [4:0] C_FLUSH  = 5'b00110;
    localparam logic [4:0] C_STALL  = 5'b11010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, dm_busy;
    logic          pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall;
    logic [1:0]    state_o;
    logic [CW-1:0] lu_cnt_o, fl_cnt_o, mw_cnt_o;

    int tests = 0;
    int fails = 0;

    wire [6:0] ctl = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, state_o};

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .dm_busy(dm_busy),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_stall(exmem_stall), .state_o(state_o),
        .lu_cnt_o(lu_cnt_o), .fl_cnt_o(fl_cnt_o), .mw_cnt_o(mw_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
        ex_redirect = 1'b0; dm_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dm_busy = 1'b1; ex_redirect = 1'b1;
        #1;
        tests++;
        if (ctl !== 7'd0) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, 7'd0); end
        tests++;
        if ({lu_cnt_o, fl_cnt_o, mw_cnt_o} !== '0)
            begin fails++; $display("FAIL reset_cnt got %h want 0", {lu_cnt_o, fl_cnt_o, mw_cnt_o}); end
        tick();
        #1;
        tests++;
        if (ctl !== 7'd0) begin fails++; $display("FAIL reset_hold got %b want %b", ctl, 7'd0); end
        rst_n = 1'b1;
        #1;
        tests++;
        if (ctl !== {C_FREEZE, 2'd0}) begin fails++; $display("FAIL reset_release got %b want %b", ctl, {C_FREEZE, 2'd0}); end
        tick();
        #1;
        tests++;
        if (ctl !== {C_FREEZE, 2'd2}) begin fails++; $display("FAIL reset_memwait got %b want %b", ctl, {C_FREEZE, 2'd2}); end
        clear_inputs();
        #1;
        tests++;
        if (ctl !== {C_IDLE, 2'd2}) begin fails++; $display("FAIL reset_wait_exit got %b want %b", ctl, {C_IDLE, 2'd2}); end
        tick();
    endtask

    task automatic test_load_use();
        // {is_load, rd, rs1, rs1_used, rs2, rs2_used, expected}
        logic [4:0] rd_t [5]  = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd9};
        logic [4:0] rs1_t [5] = '{5'd1, 5'd0, 5'd7, 5'd7, 5'd9};
        logic       u1_t [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0] rs2_t [5] = '{5'd5, 5'd0, 5'd2, 5'd3, 5'd9};
        logic       u2_t [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       ld_t [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       hz_t [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            ex_is_load = ld_t[i]; ex_rd_addr = rd_t[i];
            id_rs1_addr = rs1_t[i]; id_rs1_used = u1_t[i];
            id_rs2_addr = rs2_t[i]; id_rs2_used = u2_t[i];
            #1;
            tests++;
            if (ctl !== {(hz_t[i] ? C_STALL : C_IDLE), 2'd0})
                begin fails++; $display("FAIL load_use[%0d] got %b want %b", i, ctl, {(hz_t[i] ? C_STALL : C_IDLE), 2'd0}); end
            tick();
            clear_inputs();
            #1;
            tests++;
            if (ctl !== {C_IDLE, 2'd0}) begin fails++; $display("FAIL load_use_clear[%0d] got %b want %b", i, ctl, {C_IDLE, 2'd0}); end
            tick();
        end
    endtask

    task automatic test_redirect();
        logic [6:0] exp_seq [4] = '{{C_FLUSH, 2'd0}, {C_FLUSH, 2'd1}, {C_FLUSH, 2'd1}, {C_IDLE, 2'd0}};
        int n_flush = 0;
        clear_inputs();
        ex_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (ctl !== exp_seq[i]) begin fails++; $display("FAIL redirect[%0d] got %b want %b", i, ctl, exp_seq[i]); end
            if (ifid_flush === 1'b1) n_flush++;
            tick();
            ex_redirect = 1'b0;
        end
        tests++;
        if (n_flush !== int'(FC)) begin fails++; $display("FAIL redirect_len got %0d want %0d", n_flush, FC); end
    endtask

    task automatic test_redirect_lu();
        clear_inputs();
        ex_redirect = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd4;
        id_rs1_addr = 5'd4; id_rs1_used = 1'b1;
        #1;
        tests++;
        if (ctl !== {C_FLUSH, 2'd0}) begin fails++; $display("FAIL redirect_lu got %b want %b", ctl, {C_FLUSH, 2'd0}); end
        tick();
        ex_redirect = 1'b0;
        #1;
        tests++;
        if (ctl !== {C_FLUSH, 2'd1}) begin fails++; $display("FAIL redirect_lu_window got %b want %b", ctl, {C_FLUSH, 2'd1}); end
        tick();
        tick();
        clear_inputs();
        #1;
        tests++;
        if (ctl !== {C_IDLE, 2'd0}) begin fails++; $display("FAIL redirect_lu_end got %b want %b", ctl, {C_IDLE, 2'd0}); end
    endtask

    task automatic test_redirect_busy();
        logic [6:0] exp_seq [8] = '{{C_FREEZE, 2'd0}, {C_FREEZE, 2'd2}, {C_FREEZE, 2'd2}, {C_FREEZE, 2'd2},
                                    {C_FLUSH, 2'd2}, {C_FLUSH, 2'd1}, {C_FLUSH, 2'd1}, {C_IDLE, 2'd0}};
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            dm_busy     = (i < 4);
            ex_redirect = (i < 5);
            #1;
            tests++;
            if (ctl !== exp_seq[i]) begin fails++; $display("FAIL redirect_busy[%0d] got %b want %b", i, ctl, exp_seq[i]); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_wait_in_flush();
        logic [6:0] exp_seq [6] = '{{C_FLUSH, 2'd0}, {C_FREEZE, 2'd1}, {C_FREEZE, 2'd2},
                                    {C_FLUSH, 2'd2}, {C_FLUSH, 2'd1}, {C_IDLE, 2'd0}};
        int n_flush = 0;
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            ex_redirect = (i == 0);
            dm_busy     = (i == 1) || (i == 2);
            #1;
            tests++;
            if (ctl !== exp_seq[i]) begin fails++; $display("FAIL wait_in_flush[%0d] got %b want %b", i, ctl, exp_seq[i]); end
            if (ifid_flush === 1'b1) n_flush++;
            tick();
        end
        tests++;
        if (n_flush !== int'(FC)) begin fails++; $display("FAIL wait_in_flush_len got %0d want %0d", n_flush, FC); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        #1;
        tests++;
        if (ctl !== {C_FLUSH, 2'd1}) begin fails++; $display("FAIL reset_mid_pre got %b want %b", ctl, {C_FLUSH, 2'd1}); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (ctl !== 7'd0) begin fails++; $display("FAIL reset_mid_assert got %b want %b", ctl, 7'd0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (ctl !== {C_IDLE, 2'd0}) begin fails++; $display("FAIL reset_mid_release got %b want %b", ctl, {C_IDLE, 2'd0}); end
        tick();
    endtask

    task automatic test_perf_sat();
        logic [CW-1:0] exp_mw;
        pulse_reset();
        dm_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                exp_mw = PERF ? CW'(10) : '0;
                tests++;
                if (mw_cnt_o !== exp_mw) begin fails++; $display("FAIL perf_mw_mid got %0d want %0d", mw_cnt_o, exp_mw); end
            end
            tick();
        end
        dm_busy = 1'b0;
        #1;
        exp_mw = PERF ? CW'(15) : '0;
        tests++;
        if (mw_cnt_o !== exp_mw) begin fails++; $display("FAIL perf_mw_sat got %0d want %0d", mw_cnt_o, exp_mw); end
        tick();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        tick();
        tick();
        #1;
        tests++;
        if ({lu_cnt_o, fl_cnt_o} !== {CW'(0), (PERF ? CW'(FC) : CW'(0))})
            begin fails++; $display("FAIL perf_lu_fl got %0d/%0d want 0/%0d", lu_cnt_o, fl_cnt_o, PERF ? FC : 0); end
    endtask

    // Model: pending flush cycles plus whether the previous cycle was a memory wait.
    task automatic test_random();
        int pend = 0;
        bit was_busy = 1'b0;
        int n_lu = 0, n_fl = 0, n_mw = 0;
        bit haz;
        logic [4:0] e;
        logic [1:0] st;
        logic [6:0] exp_ctl;
        logic [3*CW-1:0] exp_cnt;
        pulse_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_n       = ($urandom_range(0, 79) != 0);
            dm_busy     = ($urandom_range(0, 4) == 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_rd_addr  = 5'($urandom_range(0, 3));
            id_rs1_addr = 5'($urandom_range(0, 3));
            id_rs2_addr = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            if (!rst_n) begin
                pend = 0; was_busy = 1'b0; n_lu = 0; n_fl = 0; n_mw = 0;
            end
            haz = ex_is_load && (ex_rd_addr != 0) &&
                  ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
            st = was_busy ? 2'd2 : ((pend > 0) ? 2'd1 : 2'd0);
            if (!rst_n)           e = C_IDLE;
            else if (dm_busy)     e = C_FREEZE;
            else if (ex_redirect) e = C_FLUSH;
            else if (pend > 0)    e = C_FLUSH;
            else if (haz)         e = C_STALL;
            else                  e = C_IDLE;
            exp_ctl = {e, st};
            exp_cnt = PERF ? {CW'((n_lu > 15) ? 15 : n_lu), CW'((n_fl > 15) ? 15 : n_fl), CW'((n_mw > 15) ? 15 : n_mw)}
                           : '0;
            #1;
            tests++;
            if (ctl !== exp_ctl) begin fails++; $display("FAIL rand_ctl[%0d] got %b want %b", cyc, ctl, exp_ctl); end
            tests++;
            if ({lu_cnt_o, fl_cnt_o, mw_cnt_o} !== exp_cnt)
                begin fails++; $display("FAIL rand_cnt[%0d] got %h want %h", cyc, {lu_cnt_o, fl_cnt_o, mw_cnt_o}, exp_cnt); end
            @(posedge clk);
            if (rst_n) begin
                if (e == C_STALL) n_lu++;
                if (e[2]) n_fl++;
                if (e[0]) n_mw++;
                was_busy = dm_busy;
                if (!dm_busy) begin
                    if (ex_redirect)   pend = int'(FC) - 1;
                    else if (pend > 0) pend--;
                end
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_lu();
        test_redirect_busy();
        test_wait_in_flush();
        test_reset_mid();
        test_perf_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
